// File: rtl/video_pattern_gen_if.sv
// Video source bundle: run request and pattern select in, framing and pixel data out.
// The generator drives through the master modport; a sink or bench uses slave.
interface video_pattern_gen_if #(
  parameter int DATA_W = 10
) ();
  logic              enable;
  logic [2:0]        mode;
  logic              busy;
  logic              frame_start;
  logic [15:0]       frame_cnt;
  logic              de;
  logic [DATA_W-1:0] data;
  logic              hsync;
  logic              vsync;
  logic              lv;
  logic              fv;

  modport master (
    input  enable, mode,
    output busy, frame_start, frame_cnt, de, data, hsync, vsync, lv, fv
  );

  modport slave (
    output enable, mode,
    input  busy, frame_start, frame_cnt, de, data, hsync, vsync, lv, fv
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Raster test-pattern source: WAIT/IDLE/RUN sequencer with pixel/line counters
// and registered DE/sync/LV/FV framing plus a frame-latched pixel pattern.
module video_pattern_gen #(
  parameter int DATA_W    = 10,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 110,
  parameter int V_ACTIVE  = 400,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 44,
  parameter int V_BP      = 20,
  parameter int CHK_LOG2  = 4,
  parameter int START_DLY = 128
) (
  input  logic                clk,
  input  logic                rstn,
  video_pattern_gen_if.master vid_io
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int BAR_W   = H_ACTIVE >> 3;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DLY - 1);
  localparam logic [DATA_W-1:0] MAX  = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [HW-1:0]     px_q, px_d;
  logic [VW-1:0]     ln_q, ln_d;
  logic [HW-1:0]     bar_cnt_q, bar_cnt_d;
  logic [2:0]        bar_q, bar_d;
  logic [2:0]        mode_q, mode_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              de_q, de_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              lv_q, fv_q;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pat_s;
  logic              chk_s;

  // State register: sequencer state, raster counters, latched mode and frame count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_WAIT;
      dly_q       <= '0;
      px_q        <= '0;
      ln_q        <= '0;
      bar_cnt_q   <= '0;
      bar_q       <= 3'd0;
      mode_q      <= 3'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      px_q        <= px_d;
      ln_q        <= ln_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_q       <= bar_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic: startup delay, frame-boundary enable sampling, raster stepping.
  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    px_d        = px_q;
    ln_d        = ln_q;
    bar_cnt_d   = bar_cnt_q;
    bar_d       = bar_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_IDLE;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      ST_IDLE: begin
        if (vid_io.enable) begin
          state_d   = ST_RUN;
          px_d      = '0;
          ln_d      = '0;
          bar_cnt_d = '0;
          bar_d     = 3'd0;
          mode_d    = vid_io.mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (px_q == H_LAST) begin
          px_d      = '0;
          bar_cnt_d = '0;
          bar_d     = 3'd0;
          if (ln_q == V_LAST) begin
            ln_d        = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (vid_io.enable) begin
              mode_d = vid_io.mode;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            ln_d = ln_q + VW'(1);
          end
        end else begin
          px_d = px_q + HW'(1);
          // Bar index steps every BAR_W pixels and parks on bar 7 for the remainder.
          if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_d     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + HW'(1);
          end
        end
      end
      default: begin
        state_d = ST_WAIT;
        dly_d   = '0;
      end
    endcase
  end

  assign chk_s = 1'((32'(px_q) >> CHK_LOG2) ^ (32'(ln_q) >> CHK_LOG2));

  // Output logic: framing decode and pattern select from the current counters.
  always_comb begin
    case (mode_q)
      3'd0:    pat_s = MAX >> bar_q;
      3'd1:    pat_s = DATA_W'(px_q);
      3'd2:    pat_s = chk_s ? MAX : '0;
      3'd3:    pat_s = DATA_W'(frame_cnt_q);
      3'd4:    pat_s = DATA_W'(ln_q);
      default: pat_s = '0;
    endcase
    if (state_q == ST_RUN) begin
      busy_d = 1'b1;
      de_d   = (px_q < H_ACT) && (ln_q < V_ACT);
      hs_d   = (px_q >= HS_FIRST) && (px_q <= HS_LAST);
      vs_d   = (ln_q >= VS_FIRST) && (ln_q <= VS_LAST);
      fs_d   = (px_q == '0) && (ln_q == '0);
    end else begin
      busy_d = 1'b0;
      de_d   = 1'b0;
      hs_d   = 1'b0;
      vs_d   = 1'b0;
      fs_d   = 1'b0;
    end
    if (de_d) begin
      data_d = pat_s;
    end else begin
      data_d = '0;
    end
  end

  // Output registers: one cycle behind the counters; LV/FV idle high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      lv_q   <= 1'b1;
      fv_q   <= 1'b1;
      fs_q   <= 1'b0;
      busy_q <= 1'b0;
      data_q <= '0;
    end else begin
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      lv_q   <= ~hs_d;
      fv_q   <= ~vs_d;
      fs_q   <= fs_d;
      busy_q <= busy_d;
      data_q <= data_d;
    end
  end

  assign vid_io.de          = de_q;
  assign vid_io.data        = data_q;
  assign vid_io.hsync       = hs_q;
  assign vid_io.vsync       = vs_q;
  assign vid_io.lv          = lv_q;
  assign vid_io.fv          = fv_q;
  assign vid_io.frame_start = fs_q;
  assign vid_io.busy        = busy_q;
  assign vid_io.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed plus randomized bench for video_pattern_gen, checked every cycle against
// a frame-position reference model (x = pos mod H_TOTAL, y = pos div H_TOTAL).
module tb_video_pattern_gen;

  localparam int DW        = 10;
  localparam int H_ACTIVE  = 16;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 2;
  localparam int H_BP      = 2;
  localparam int V_ACTIVE  = 4;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 1;
  localparam int V_BP      = 1;
  localparam int CHK       = 2;
  localparam int START_DLY = 4;
  localparam int HT        = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT        = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME     = HT * VT;
  localparam int MAXV      = (1 << DW) - 1;

  logic clk;
  logic rstn;
  int   n_assert;
  int   n_fail;

  int   m_phase;
  int   m_dly;
  int   m_pos;
  int   m_mode;
  int   m_fc;

  video_pattern_gen_if #(.DATA_W(DW)) vif ();

  video_pattern_gen #(
    .DATA_W(DW), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CHK_LOG2(CHK), .START_DLY(START_DLY)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .vid_io (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int pat(input int md, input int x, input int y, input int fc);
    int b;
    case (md)
      0: begin
        b = x / (H_ACTIVE / 8);
        if (b > 7) b = 7;
        return MAXV >> b;
      end
      1: return x % (MAXV + 1);
      2: return (((x >> CHK) + (y >> CHK)) % 2 == 1) ? MAXV : 0;
      3: return fc % (MAXV + 1);
      4: return y % (MAXV + 1);
      default: return 0;
    endcase
  endfunction

  task automatic step();
    int e_de, e_hs, e_vs, e_fs, e_busy, e_data, x, y;
    e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_busy = 0; e_data = 0;
    if (rstn === 1'b1 && m_phase == 2) begin
      x      = m_pos % HT;
      y      = m_pos / HT;
      e_busy = 1;
      e_fs   = (m_pos == 0) ? 1 : 0;
      e_de   = (x < H_ACTIVE && y < V_ACTIVE) ? 1 : 0;
      e_hs   = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? 1 : 0;
      e_vs   = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? 1 : 0;
      e_data = (e_de == 1) ? pat(m_mode, x, y, m_fc) : 0;
    end
    if (rstn !== 1'b1) begin
      m_phase = 0; m_dly = 0; m_pos = 0; m_mode = 0; m_fc = 0;
    end else if (m_phase == 0) begin
      if (m_dly == START_DLY - 1) begin
        m_phase = 1;
        m_dly   = 0;
      end else begin
        m_dly++;
      end
    end else if (m_phase == 1) begin
      if (vif.enable === 1'b1) begin
        m_phase = 2;
        m_pos   = 0;
        m_mode  = int'(vif.mode);
      end
    end else begin
      if (m_pos == FRAME - 1) begin
        m_fc  = (m_fc + 1) % 65536;
        m_pos = 0;
        if (vif.enable === 1'b1) m_mode = int'(vif.mode);
        else m_phase = 1;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
    chk("de",          32'(vif.de),          32'(e_de));
    chk("data",        32'(vif.data),        32'(e_data));
    chk("hsync",       32'(vif.hsync),       32'(e_hs));
    chk("vsync",       32'(vif.vsync),       32'(e_vs));
    chk("lv",          32'(vif.lv),          32'(1 - e_hs));
    chk("fv",          32'(vif.fv),          32'(1 - e_vs));
    chk("busy",        32'(vif.busy),        32'(e_busy));
    chk("frame_start", 32'(vif.frame_start), 32'(e_fs));
    chk("frame_cnt",   32'(vif.frame_cnt),   32'(m_fc));
  endtask

  task automatic run_to(input int pos);
    int k;
    k = 0;
    while (!(m_phase == 2 && m_pos == pos) && k < 4 * FRAME) begin
      step();
      k++;
    end
    chk("reach_pos", 32'((m_phase == 2 && m_pos == pos) ? 1 : 0), 32'(1));
  endtask

  task automatic run_to_idle();
    int k;
    k = 0;
    while (m_phase != 1 && k < 4 * FRAME) begin
      step();
      k++;
    end
    chk("reach_idle", 32'((m_phase == 1) ? 1 : 0), 32'(1));
  endtask

  task automatic start_latency();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (vif.frame_start !== 1'b1 && k < 20);
    chk("start_latency", 32'(k), 32'(6));
    chk("first_de", 32'(vif.de), 32'(1));
  endtask

  initial begin
    logic [9:0] bars [8];
    int fc0, vs_cnt;
    bars = '{10'h3FF, 10'h1FF, 10'h0FF, 10'h07F, 10'h03F, 10'h01F, 10'h00F, 10'h007};
    n_assert = 0; n_fail = 0;
    m_phase = 0; m_dly = 0; m_pos = 0; m_mode = 0; m_fc = 0;
    rstn = 1'b0;
    vif.enable = 1'b1;
    vif.mode   = 3'd1;
    step();
    step();
    chk("rst_lv", 32'(vif.lv), 32'(1));
    chk("rst_fc", 32'(vif.frame_cnt), 32'(0));

    rstn = 1'b1;
    start_latency();
    chk("ramp0", 32'(vif.data), 32'(0));
    for (int i = 1; i < 16; i++) begin
      step();
      chk("ramp", 32'(vif.data), 32'(i));
    end
    step();
    chk("de_fall", 32'(vif.de), 32'(0));
    step();
    chk("hs_pre", 32'(vif.hsync), 32'(0));
    step();
    chk("hs_on", 32'(vif.hsync), 32'(1));
    step();
    chk("hs_on2", 32'(vif.hsync), 32'(1));
    step();
    chk("hs_off", 32'(vif.hsync), 32'(0));
    step();
    step();
    chk("line1_de", 32'(vif.de), 32'(1));

    vif.mode = 3'd0;
    run_to(0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("bar", 32'(vif.data), 32'(bars[i / 2]));
    end
    vs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (vif.vsync === 1'b1) vs_cnt++;
    end
    chk("vsync_cycles", 32'(vs_cnt), 32'(22));

    fc0 = int'(vif.frame_cnt);
    run_to(70);
    vif.enable = 1'b0;
    run_to_idle();
    step();
    chk("fc_after_drop", 32'(vif.frame_cnt), 32'(fc0 + 1));
    chk("busy_fell", 32'(vif.busy), 32'(0));
    step();
    step();
    vif.enable = 1'b1;
    step();
    step();
    chk("restart_fs", 32'(vif.frame_start), 32'(1));

    vif.mode = 3'd2;
    run_to(0);
    run_to(60);
    vif.mode = 3'd3;
    run_to(0);
    for (int i = 0; i < FRAME - 1; i++) begin
      step();
      if (vif.de === 1'b1) chk("frame_id", 32'(vif.data), 32'(m_fc % (MAXV + 1)));
    end

    run_to(30);
    rstn = 1'b0;
    step();
    chk("rst_de", 32'(vif.de), 32'(0));
    chk("rst_fc_mid", 32'(vif.frame_cnt), 32'(0));
    chk("rst_fv", 32'(vif.fv), 32'(1));
    rstn = 1'b1;
    start_latency();
    run_to(40);
    force dut.frame_cnt_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    step();
    release dut.frame_cnt_q;
    chk("preload", 32'(vif.frame_cnt), 32'(16'hFFFF));
    run_to(0);
    chk("fc_wrap", 32'(vif.frame_cnt), 32'(0));

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) vif.enable = ~vif.enable;
      if ($urandom_range(0, 31) == 0) vif.mode = 3'($urandom_range(0, 7));
      rstn = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
